serdes_rx_word_aligner: RTL and testbench

Parametrised word aligner placed between the deserializer's raw DATA_WIDTH word output and the link layer. It is the next-generation replacement for the fixed passthrough RX data path.
- Hunts for SYNC_PATTERN at any bit offset across two consecutive raw words.
- Confirms the offset with LOCK_CNT consecutive hits.
- Presents bit-aligned words with rx_locked/rx_valid.
- Drops lock after UNLOCK_CNT consecutive misses while alignment checking is requested.

---
 rtl/serdes_rx_word_aligner_if.sv | 26 ++
 rtl/serdes_rx_word_aligner.sv | 176 +++++++++++++++++
 tb/tb_serdes_rx_word_aligner.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serdes_rx_word_aligner_if.sv
// Lane-side bundle for the RX word aligner: control inputs, raw word in,
// aligned word and lock status out.
interface serdes_rx_word_aligner_if #(
    parameter int DATA_WIDTH = 8
);
    localparam int OFF_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  enable;
    logic                  rx_align;
    logic [DATA_WIDTH-1:0] rx_data_in;
    logic [DATA_WIDTH-1:0] rx_data_out;
    logic                  rx_locked;
    logic                  rx_valid;
    logic [OFF_W-1:0]      rx_offset;
    logic                  rx_slip;

    modport master (
        output enable, rx_align, rx_data_in,
        input  rx_data_out, rx_locked, rx_valid, rx_offset, rx_slip
    );

    modport slave (
        input  enable, rx_align, rx_data_in,
        output rx_data_out, rx_locked, rx_valid, rx_offset, rx_slip
    );
endinterface

// File: rtl/serdes_rx_word_aligner.sv
// Finds SYNC_PATTERN at any bit offset across two consecutive raw words,
// confirms the offset, then presents bit-aligned words with lock/slip status.
//
// state     | meaning
// ST_HUNT   | searching every offset for the sync pattern
// ST_VERIFY | offset captured, counting consecutive hits at that offset
// ST_LOCKED | offset confirmed, output valid; misses counted while rx_align=1
module serdes_rx_word_aligner #(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN =
        ({(DATA_WIDTH/8){8'h55}} << 8) | DATA_WIDTH'(8'hBC),
    parameter int                    LOCK_CNT     = 4,
    parameter int                    UNLOCK_CNT   = 4
) (
    input logic                     rxclk,
    input logic                     rx_reset,
    serdes_rx_word_aligner_if.slave bus
);
    localparam int OFF_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int WIN_W = 2 * DATA_WIDTH;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] LOCK_TC   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_TC = 4'(UNLOCK_CNT);

    logic [DATA_WIDTH-1:0] prev;
    logic [1:0]            state;
    logic [OFF_W-1:0]      offset;
    logic [3:0]            hit_cnt;
    logic [3:0]            miss_cnt;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  locked_q;
    logic                  slip_q;

    logic [1:0]            state_nx;
    logic [OFF_W-1:0]      offset_nx;
    logic [3:0]            hit_nx;
    logic [3:0]            miss_nx;
    logic                  locked_nx;
    logic                  slip_nx;
    logic [DATA_WIDTH-1:0] data_nx;

    logic [WIN_W-1:0]      window;
    logic [DATA_WIDTH-1:0] hit_vec;
    logic                  match_any;
    logic [OFF_W-1:0]      k_hit;
    logic [DATA_WIDTH-1:0] cand;
    logic                  cand_match;
    logic [3:0]            hit_inc;
    logic [3:0]            miss_inc;

    // Newest word in the MSBs: bit 0 of prev is the oldest received bit.
    assign window = {bus.rx_data_in, prev};

    always_comb begin
        hit_vec = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            hit_vec[k] = (window[k +: DATA_WIDTH] == SYNC_PATTERN);
        end
    end

    // Scanning downward leaves the lowest matching offset in k_hit.
    always_comb begin
        match_any = |hit_vec;
        k_hit     = '0;
        for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                k_hit = OFF_W'(k);
            end
        end
    end

    assign cand       = window[offset +: DATA_WIDTH];
    assign cand_match = (cand == SYNC_PATTERN);

    assign hit_inc  = (hit_cnt  == 4'hF) ? hit_cnt  : hit_cnt  + 4'd1;
    assign miss_inc = (miss_cnt == 4'hF) ? miss_cnt : miss_cnt + 4'd1;

    always_comb begin
        state_nx  = state;
        offset_nx = offset;
        hit_nx    = hit_cnt;
        miss_nx   = miss_cnt;
        locked_nx = locked_q;
        slip_nx   = 1'b0;
        if (!bus.enable) begin
            state_nx  = ST_HUNT;
            hit_nx    = '0;
            miss_nx   = '0;
            locked_nx = 1'b0;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (bus.rx_align && match_any) begin
                        offset_nx = k_hit;
                        hit_nx    = 4'd1;
                        if (LOCK_TC == 4'd1) begin
                            state_nx  = ST_LOCKED;
                            locked_nx = 1'b1;
                        end else begin
                            state_nx = ST_VERIFY;
                        end
                    end
                end
                ST_VERIFY: begin
                    // A hit at some other offset still counts as a miss here;
                    // HUNT picks the new offset up on the following cycle.
                    if (bus.rx_align && cand_match) begin
                        hit_nx = hit_inc;
                        if (hit_inc >= LOCK_TC) begin
                            state_nx  = ST_LOCKED;
                            locked_nx = 1'b1;
                        end
                    end else begin
                        state_nx = ST_HUNT;
                        hit_nx   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (bus.rx_align) begin
                        if (cand_match) begin
                            miss_nx = '0;
                        end else if (miss_inc >= UNLOCK_TC) begin
                            state_nx  = ST_HUNT;
                            locked_nx = 1'b0;
                            slip_nx   = 1'b1;
                            miss_nx   = '0;
                            hit_nx    = '0;
                        end else begin
                            miss_nx = miss_inc;
                        end
                    end
                end
                default: begin
                    state_nx  = ST_HUNT;
                    hit_nx    = '0;
                    miss_nx   = '0;
                    locked_nx = 1'b0;
                end
            endcase
        end
    end

    assign data_nx = locked_nx ? cand : '0;

    always_ff @(posedge rxclk or posedge rx_reset) begin
        if (rx_reset) begin
            prev     <= '0;
            state    <= ST_HUNT;
            offset   <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            data_q   <= '0;
            locked_q <= 1'b0;
            slip_q   <= 1'b0;
        end else begin
            prev     <= bus.rx_data_in;
            state    <= state_nx;
            offset   <= offset_nx;
            hit_cnt  <= hit_nx;
            miss_cnt <= miss_nx;
            data_q   <= data_nx;
            locked_q <= locked_nx;
            slip_q   <= slip_nx;
        end
    end

    assign bus.rx_data_out = data_q;
    assign bus.rx_locked   = locked_q;
    assign bus.rx_valid    = locked_q;
    assign bus.rx_offset   = offset;
    assign bus.rx_slip     = slip_q;
endmodule

// File: tb/tb_serdes_rx_word_aligner.sv
// Bench for serdes_rx_word_aligner: directed lock/slip/enable/reset scenarios
// plus a randomized stream checked against a behavioural model.
`timescale 1ns/1ps
module tb_serdes_rx_word_aligner;
    logic rxclk = 1'b0;
    logic rx_reset = 1'b1;
    always #5 rxclk = ~rxclk;

    serdes_rx_word_aligner_if #(.DATA_WIDTH(8))  if8 ();
    serdes_rx_word_aligner_if #(.DATA_WIDTH(16)) if16 ();

    serdes_rx_word_aligner #(.DATA_WIDTH(8)) dut8 (
        .rxclk(rxclk), .rx_reset(rx_reset), .bus(if8)
    );
    serdes_rx_word_aligner #(.DATA_WIDTH(16)) dut16 (
        .rxclk(rxclk), .rx_reset(rx_reset), .bus(if16)
    );

    int total = 0;
    int bad = 0;

    // Reference model of the 8-bit lane
    localparam int LOCK = 4;
    localparam int UNLOCK = 4;
    logic [7:0] m_prev;
    int         m_hits, m_miss, m_off;
    bit         m_verify, m_locked, m_slip;
    logic [7:0] m_data;
    logic [7:0]  last_a = 8'h00;
    logic [15:0] last16 = 16'h0000;

    function automatic int lowest_hit(input logic [15:0] w);
        for (int k = 0; k < 8; k++)
            if (((w >> k) & 16'h00FF) == 16'h00BC) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = 8'h00; m_hits = 0; m_miss = 0; m_off = 0;
        m_verify = 0; m_locked = 0; m_slip = 0; m_data = 8'h00;
    endtask

    task automatic model_step(input logic en, input logic al, input logic [7:0] din);
        logic [15:0] w;
        logic [7:0]  seen;
        int          kh;
        bit          cand;
        w    = {din, m_prev};
        kh   = lowest_hit(w);
        seen = 8'((w >> m_off) & 16'h00FF);
        cand = (seen == 8'hBC);
        m_prev = din;
        m_slip = 0;
        if (!en) begin
            m_verify = 0; m_locked = 0; m_hits = 0; m_miss = 0;
        end else if (m_locked) begin
            if (al) begin
                if (cand) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_miss >= UNLOCK) begin
                        m_locked = 0; m_slip = 1; m_miss = 0; m_hits = 0;
                    end
                end
            end
        end else if (m_verify) begin
            if (al && cand) begin
                m_hits++;
                if (m_hits >= LOCK) begin m_verify = 0; m_locked = 1; end
            end else begin
                m_verify = 0; m_hits = 0;
            end
        end else if (al && kh >= 0) begin
            m_off = kh; m_hits = 1;
            if (LOCK == 1) m_locked = 1; else m_verify = 1;
        end
        m_data = m_locked ? seen : 8'h00;
    endtask

    // Sends aligned word a at bit shift k on the 8-bit lane; returns #1 after the edge.
    task automatic send(input logic [7:0] a, input int k, input logic al, input logic en);
        logic [15:0] ext;
        @(negedge rxclk);
        ext = ({8'h00, a} << k) | ({8'h00, last_a} >> (8 - k));
        if8.rx_data_in = ext[7:0];
        if8.rx_align   = al;
        if8.enable     = en;
        last_a = a;
        @(posedge rxclk);
        model_step(en, al, ext[7:0]);
        #1;
    endtask

    task automatic send16(input logic [15:0] a, input logic al, input logic en);
        logic [31:0] ext;
        @(negedge rxclk);
        ext = ({16'h0000, a} << 11) | ({16'h0000, last16} >> 5);
        if16.rx_data_in = ext[15:0];
        if16.rx_align   = al;
        if16.enable     = en;
        last16 = a;
        @(posedge rxclk);
        model_step(if8.enable, if8.rx_align, if8.rx_data_in);
        #1;
    endtask

    task automatic test_reset();
        if8.enable = 0; if8.rx_align = 0; if8.rx_data_in = 8'h00;
        if16.enable = 0; if16.rx_align = 0; if16.rx_data_in = 16'h0000;
        model_reset();
        @(posedge rxclk); #2;
        total++;
        if ({if8.rx_locked, if8.rx_valid, if8.rx_slip, if8.rx_data_out, if8.rx_offset} !== 14'h0) begin
            bad++;
            $display("FAIL reset_state got lk=%b v=%b s=%b d=%h o=%0d want all 0",
                     if8.rx_locked, if8.rx_valid, if8.rx_slip, if8.rx_data_out, if8.rx_offset);
        end
        rx_reset = 0;
        #1;
        total++;
        if ({if16.rx_locked, if16.rx_data_out} !== 17'h0) begin
            bad++;
            $display("FAIL reset_state16 got lk=%b d=%h want 0", if16.rx_locked, if16.rx_data_out);
        end
    endtask

    task automatic test_lock();
        send(8'hBC, 3, 0, 1);
        send(8'hBC, 3, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            send(8'hBC, 3, 1, 1);
            total++;
            if (if8.rx_locked !== (i == 4)) begin
                bad++;
                $display("FAIL lock_hit%0d got locked=%b want %b", i, if8.rx_locked, (i == 4));
            end
        end
        total++;
        if (if8.rx_offset !== 3'd3) begin
            bad++;
            $display("FAIL lock_offset got %0d want 3", if8.rx_offset);
        end
        send(8'hBC, 3, 1, 1);
        total++;
        if (if8.rx_data_out !== 8'hBC || if8.rx_valid !== 1'b1) begin
            bad++;
            $display("FAIL lock_data got d=%h v=%b want BC 1", if8.rx_data_out, if8.rx_valid);
        end
    endtask

    task automatic test_payload();
        logic [7:0] pay [3] = '{8'h12, 8'h34, 8'h56};
        send(pay[0], 3, 0, 1);
        for (int i = 1; i < 3; i++) begin
            send(pay[i], 3, 0, 1);
            total++;
            if (if8.rx_data_out !== pay[i-1] || if8.rx_locked !== 1'b1) begin
                bad++;
                $display("FAIL payload%0d got d=%h lk=%b want %h 1",
                         i, if8.rx_data_out, if8.rx_locked, pay[i-1]);
            end
        end
    endtask

    task automatic test_slip();
        int slip_at = 0;
        int lock_at = 0;
        for (int i = 1; i <= 10; i++) begin
            send(8'hBC, 5, 1, 1);
            if (if8.rx_slip === 1'b1 && slip_at == 0) slip_at = i;
            if (if8.rx_locked === 1'b1 && slip_at != 0 && lock_at == 0) lock_at = i;
            total++;
            if (if8.rx_slip !== m_slip || if8.rx_locked !== m_locked) begin
                bad++;
                $display("FAIL slip_model%0d got s=%b lk=%b want %b %b",
                         i, if8.rx_slip, if8.rx_locked, m_slip, m_locked);
            end
        end
        total++;
        if (slip_at != 4) begin
            bad++;
            $display("FAIL slip_cycle got %0d want 4", slip_at);
        end
        total++;
        if (lock_at != 8 || if8.rx_offset !== 3'd5) begin
            bad++;
            $display("FAIL relock got cycle=%0d off=%0d want 8 5", lock_at, if8.rx_offset);
        end
    endtask

    task automatic test_enable();
        send(8'hBC, 5, 1, 0);
        total++;
        if ({if8.rx_locked, if8.rx_slip, if8.rx_data_out} !== 10'h0) begin
            bad++;
            $display("FAIL enable_off got lk=%b s=%b d=%h want 0 0 00",
                     if8.rx_locked, if8.rx_slip, if8.rx_data_out);
        end
        for (int i = 1; i <= 4; i++) begin
            send(8'hBC, 5, 1, 1);
            total++;
            if (if8.rx_locked !== (i == 4)) begin
                bad++;
                $display("FAIL enable_relock%0d got %b want %b", i, if8.rx_locked, (i == 4));
            end
        end
    endtask

    task automatic test_verify_break();
        send(8'hBC, 3, 0, 0);
        send(8'hBC, 3, 0, 1);
        send(8'hBC, 3, 0, 1);
        send(8'hBC, 3, 1, 1);
        send(8'h00, 3, 1, 1);
        total++;
        if (m_hits != 2 || if8.rx_locked !== 1'b0) begin
            bad++;
            $display("FAIL verify_two_hits got lk=%b hits=%0d want 0 2", if8.rx_locked, m_hits);
        end
        send(8'hBC, 3, 1, 1);
        total++;
        if (if8.rx_locked !== 1'b0 || m_verify) begin
            bad++;
            $display("FAIL verify_break got lk=%b verify=%b want 0 0", if8.rx_locked, m_verify);
        end
        for (int i = 1; i <= 4; i++) begin
            send(8'hBC, 3, 1, 1);
            total++;
            if (if8.rx_locked !== (i == 4)) begin
                bad++;
                $display("FAIL verify_fresh%0d got %b want %b", i, if8.rx_locked, (i == 4));
            end
        end
    endtask

    task automatic test_async_reset();
        send(8'hBC, 3, 1, 1);
        #1 rx_reset = 1;
        #1;
        total++;
        if ({if8.rx_locked, if8.rx_slip, if8.rx_valid, if8.rx_data_out} !== 11'h0) begin
            bad++;
            $display("FAIL async_reset got lk=%b s=%b v=%b d=%h want 0",
                     if8.rx_locked, if8.rx_slip, if8.rx_valid, if8.rx_data_out);
        end
        model_reset();
        rx_reset = 0;
        for (int i = 1; i <= 6; i++) begin
            send(8'hBC, 3, 1, 1);
            total++;
            if (if8.rx_locked !== m_locked || if8.rx_data_out !== m_data) begin
                bad++;
                $display("FAIL after_reset%0d got lk=%b d=%h want %b %h",
                         i, if8.rx_locked, if8.rx_data_out, m_locked, m_data);
            end
        end
        total++;
        if (if8.rx_locked !== 1'b1) begin
            bad++;
            $display("FAIL after_reset_lock got %b want 1", if8.rx_locked);
        end
    endtask

    task automatic test_random();
        int k = 0;
        logic [7:0] a;
        logic al, en;
        for (int i = 0; i < 400; i++) begin
            if (i % 12 == 0) k = $urandom_range(7, 0);
            a  = ($urandom_range(99, 0) < 70) ? 8'hBC : 8'($urandom);
            al = ($urandom_range(99, 0) < 85);
            en = ($urandom_range(99, 0) < 97);
            send(a, k, al, en);
            total++;
            if ({if8.rx_locked, if8.rx_valid, if8.rx_slip, if8.rx_data_out} !==
                {m_locked, m_locked, m_slip, m_data}) begin
                bad++;
                $display("FAIL random%0d got lk=%b v=%b s=%b d=%h want %b %b %b %h", i,
                         if8.rx_locked, if8.rx_valid, if8.rx_slip, if8.rx_data_out,
                         m_locked, m_locked, m_slip, m_data);
            end
            if (m_locked || m_verify) begin
                total++;
                if (if8.rx_offset !== 3'(m_off)) begin
                    bad++;
                    $display("FAIL random_off%0d got %0d want %0d", i, if8.rx_offset, m_off);
                end
            end
        end
    endtask

    task automatic test_wide();
        send16(16'h55BC, 0, 1);
        send16(16'h55BC, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            send16(16'h55BC, 1, 1);
            total++;
            if (if16.rx_locked !== (i == 4)) begin
                bad++;
                $display("FAIL wide_hit%0d got %b want %b", i, if16.rx_locked, (i == 4));
            end
        end
        total++;
        if (if16.rx_offset !== 4'd11) begin
            bad++;
            $display("FAIL wide_offset got %0d want 11", if16.rx_offset);
        end
        send16(16'h55BC, 1, 1);
        total++;
        if (if16.rx_data_out !== 16'h55BC) begin
            bad++;
            $display("FAIL wide_data got %h want 55BC", if16.rx_data_out);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_payload();
        test_slip();
        test_enable();
        test_verify_break();
        test_async_reset();
        test_random();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
